// File: rtl/dual_conf_avmm_arb_pkg.sv
// Purpose: shared constants, state encoding and helpers for the dual_conf CSR arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: CSR offsets, trigger bit index, grant-pointer width, one-hot FSM states.
package dual_conf_avmm_arb_pkg;

  localparam logic [2:0] DC_OFS_TRIG = 3'd0;  // reconfig trigger register
  localparam logic [2:0] DC_OFS_CFG  = 3'd1;  // configuration select
  localparam logic [2:0] DC_OFS_BUSY = 3'd2;  // reconfig busy status
  localparam int         DC_TRIG_BIT = 0;     // writing 1 here starts reconfiguration
  localparam int         PTR_W       = 2;     // enough for up to 4 requesters

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_SETUP  = 6'b000010,
    ST_STROBE = 6'b000100,
    ST_WAIT   = 6'b001000,
    ST_ACK    = 6'b010000,
    ST_LOCKED = 6'b100000
  } arb_state_t;

  // True when a write to this offset/data would start reconfiguration.
  function automatic logic is_trigger(input logic [2:0] addr, input logic [31:0] wdata);
    return (addr == DC_OFS_TRIG) && wdata[DC_TRIG_BIT];
  endfunction

endpackage

// File: rtl/dual_conf_avmm_arb_if.sv
// Purpose: bundles the requester side and the dual_conf Avalon-MM side of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold rd/wr until their ack pulse; dual_conf has no waitrequest.
// Modports: master = arbiter view (drives acks and dc_* strobes),
//           slave  = environment view (requesters plus the dual_conf slave).
interface dual_conf_avmm_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    i_req_rd;
  logic [NREQ-1:0]    i_req_wr;
  logic [3*NREQ-1:0]  i_req_addr;
  logic [32*NREQ-1:0] i_req_wdata;
  logic [NREQ-1:0]    o_req_ack;
  logic [31:0]        o_req_rdata;
  logic [2:0]         o_dc_addr;
  logic               o_dc_read;
  logic               o_dc_write;
  logic [31:0]        o_dc_writedata;
  logic [31:0]        i_dc_readdata;
  logic               o_busy;
  logic               o_locked;

  modport master (
    input  i_req_rd, i_req_wr, i_req_addr, i_req_wdata, i_dc_readdata,
    output o_req_ack, o_req_rdata, o_dc_addr, o_dc_read, o_dc_write,
           o_dc_writedata, o_busy, o_locked
  );

  modport slave (
    output i_req_rd, i_req_wr, i_req_addr, i_req_wdata, i_dc_readdata,
    input  o_req_ack, o_req_rdata, o_dc_addr, o_dc_read, o_dc_write,
           o_dc_writedata, o_busy, o_locked
  );
endinterface

// File: rtl/dual_conf_avmm_arb_rr_pick.sv
// Purpose: round-robin pick of one pending requester, searching upward from ptr with wrap.
// Latency: combinational.
// Backpressure: none; the caller only consumes the grant while idle.
// Ports: pending (per requester), ptr (search start) -> grant_idx, grant_vld.
module dual_conf_rr_pick
  import dual_conf_avmm_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Walk distances from the farthest to the nearest so the requester closest to
  // ptr (in wrap order) is the last assignment and therefore wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      for (int k = 0; k < NREQ; k++) begin
        if (pending[k] && (((int'(ptr) + j) % NREQ) == k)) begin
          grant_idx = PTR_W'(k);
          grant_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dual_conf_avmm_arb.sv
// Purpose: round-robin sharing of the dual_conf CSR slave, one transaction at a time.
// Latency: grant edge = cycle 0; write ack in cycle 3, read ack in cycle 3+RD_LAT.
// Backpressure: requesters hold their request until ack; after a trigger write all access is refused.
// Ports: i_clk, i_rst (async, active-high), bus (dual_conf_avmm_arb_if.master).
module dual_conf_avmm_arb
  import dual_conf_avmm_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int RD_LAT       = 1,
  parameter int LOCK_ON_TRIG = 1
) (
  input logic                  i_clk,
  input logic                  i_rst,
  dual_conf_avmm_arb_if.master bus
);

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_q;
  logic             op_wr_q;
  logic [1:0]       wait_cnt;

  logic [NREQ-1:0]  pending;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;
  logic [PTR_W-1:0] ptr_nxt;
  logic             sel_wr;
  logic [2:0]       sel_addr;
  logic [31:0]      sel_wdata;

  assign pending = bus.i_req_rd | bus.i_req_wr;

  dual_conf_rr_pick #(.NREQ(NREQ)) u_pick (
    .pending   (pending),
    .ptr       (ptr),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

  // Mux the picked requester's op/addr/data; rd+wr together counts as a write.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == PTR_W'(k)) begin
        sel_wr    = bus.i_req_wr[k];
        sel_addr  = bus.i_req_addr[3*k +: 3];
        sel_wdata = bus.i_req_wdata[32*k +: 32];
      end
    end
    ptr_nxt = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state              <= ST_IDLE;
      ptr                <= '0;
      gnt_q              <= '0;
      op_wr_q            <= 1'b0;
      wait_cnt           <= '0;
      bus.o_req_ack      <= '0;
      bus.o_req_rdata    <= '0;
      bus.o_dc_addr      <= '0;
      bus.o_dc_read      <= 1'b0;
      bus.o_dc_write     <= 1'b0;
      bus.o_dc_writedata <= '0;
      bus.o_busy         <= 1'b0;
      bus.o_locked       <= 1'b0;
    end else begin
      // Strobes and ack are single-cycle pulses unless re-asserted below.
      bus.o_req_ack  <= '0;
      bus.o_dc_read  <= 1'b0;
      bus.o_dc_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state              <= ST_SETUP;
            gnt_q              <= pick_idx;
            ptr                <= ptr_nxt;
            op_wr_q            <= sel_wr;
            bus.o_dc_addr      <= sel_addr;
            bus.o_dc_writedata <= sel_wdata;
            bus.o_busy         <= 1'b1;
          end
        end
        ST_SETUP: begin
          state <= ST_STROBE;
          if (op_wr_q) bus.o_dc_write <= 1'b1;
          else         bus.o_dc_read  <= 1'b1;
        end
        ST_STROBE: begin
          if (op_wr_q) begin
            state         <= ST_ACK;
            bus.o_req_ack <= NREQ'(1) << gnt_q;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= 2'(RD_LAT);
          end
        end
        ST_WAIT: begin
          // The count reaching zero on this edge is when readdata is valid.
          if (wait_cnt == 2'd1) begin
            state           <= ST_ACK;
            bus.o_req_rdata <= bus.i_dc_readdata;
            bus.o_req_ack   <= NREQ'(1) << gnt_q;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_ACK: begin
          bus.o_busy <= 1'b0;
          if ((LOCK_ON_TRIG != 0) && op_wr_q && is_trigger(bus.o_dc_addr, bus.o_dc_writedata)) begin
            state        <= ST_LOCKED;
            bus.o_locked <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOCKED: state <= ST_LOCKED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_conf_avmm_arb.sv
// Purpose: directed self-checking bench for dual_conf_avmm_arb (locking and non-locking builds).
// Latency: checks sampled on the falling edge; cycle n = n-th falling edge after the grant edge.
// Backpressure: requesters hold requests until ack, then drop them.
module tb_dual_conf_avmm_arb;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [5:0]  req_addr;
  logic [63:0] req_wdata;

  always #5 clk = ~clk;

  dual_conf_avmm_arb_if #(.NREQ(2)) bus0 ();
  dual_conf_avmm_arb_if #(.NREQ(2)) bus1 ();

  assign bus0.i_req_rd    = req_rd;
  assign bus0.i_req_wr    = req_wr;
  assign bus0.i_req_addr  = req_addr;
  assign bus0.i_req_wdata = req_wdata;
  assign bus1.i_req_rd    = req_rd;
  assign bus1.i_req_wr    = req_wr;
  assign bus1.i_req_addr  = req_addr;
  assign bus1.i_req_wdata = req_wdata;

  dual_conf_avmm_arb #(.NREQ(2), .RD_LAT(1), .LOCK_ON_TRIG(1)) dut0 (
    .i_clk (clk), .i_rst (rst), .bus (bus0.master)
  );
  dual_conf_avmm_arb #(.NREQ(2), .RD_LAT(1), .LOCK_ON_TRIG(0)) dut1 (
    .i_clk (clk), .i_rst (rst), .bus (bus1.master)
  );

  // dual_conf register models: offset 2 (busy status) reads 0x1, others read back writes.
  logic [31:0] regs0 [8];
  logic [31:0] regs1 [8];
  always @(posedge clk) begin
    if (bus0.o_dc_write) regs0[bus0.o_dc_addr] <= bus0.o_dc_writedata;
    if (bus0.o_dc_read)  bus0.i_dc_readdata <= (bus0.o_dc_addr == 3'd2) ? 32'h1 : regs0[bus0.o_dc_addr];
    if (bus1.o_dc_write) regs1[bus1.o_dc_addr] <= bus1.o_dc_writedata;
    if (bus1.o_dc_read)  bus1.i_dc_readdata <= (bus1.o_dc_addr == 3'd2) ? 32'h1 : regs1[bus1.o_dc_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic act0;
    logic got1;
    rst = 1'b1; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    cyc(); cyc();

    // Reset state
    chk("rst_ack",    {30'd0, bus0.o_req_ack}, 0);
    chk("rst_rdata",  bus0.o_req_rdata, 0);
    chk("rst_strobe", {30'd0, bus0.o_dc_read, bus0.o_dc_write}, 0);
    chk("rst_addr",   {29'd0, bus0.o_dc_addr}, 0);
    chk("rst_wdata",  bus0.o_dc_writedata, 0);
    chk("rst_flags",  {30'd0, bus0.o_busy, bus0.o_locked}, 0);
    rst = 1'b0;

    // 1: single write req0 addr=1 data=0x3
    req_wr = 2'b01; req_addr[2:0] = 3'd1; req_wdata[31:0] = 32'h3;
    cyc();
    chk("t1_c1_busy", bus0.o_busy, 1);
    chk("t1_c1_wr",   bus0.o_dc_write, 0);
    chk("t1_c1_ack",  {30'd0, bus0.o_req_ack}, 0);
    cyc();
    chk("t1_c2_wr",    bus0.o_dc_write, 1);
    chk("t1_c2_rd",    bus0.o_dc_read, 0);
    chk("t1_c2_addr",  {29'd0, bus0.o_dc_addr}, 1);
    chk("t1_c2_wdata", bus0.o_dc_writedata, 32'h3);
    cyc();
    chk("t1_c3_ack",   {30'd0, bus0.o_req_ack}, 1);
    chk("t1_c3_wr",    bus0.o_dc_write, 0);
    chk("t1_c3_busy",  bus0.o_busy, 1);
    chk("t1_c3_ack1",  {30'd0, bus1.o_req_ack}, 1);
    req_wr = 2'b00;
    cyc();
    chk("t1_c4_ack",  {30'd0, bus0.o_req_ack}, 0);
    chk("t1_c4_busy", bus0.o_busy, 0);

    // 2: read req1 addr=2, model returns 0x1
    req_rd = 2'b10; req_addr[5:3] = 3'd2;
    cyc();
    chk("t2_c1_busy", bus0.o_busy, 1);
    cyc();
    chk("t2_c2_rd",   bus0.o_dc_read, 1);
    chk("t2_c2_wr",   bus0.o_dc_write, 0);
    chk("t2_c2_addr", {29'd0, bus0.o_dc_addr}, 2);
    cyc();
    chk("t2_c3_rd",   bus0.o_dc_read, 0);
    chk("t2_c3_ack",  {30'd0, bus0.o_req_ack}, 0);
    cyc();
    chk("t2_c4_ack",   {30'd0, bus0.o_req_ack}, 2);
    chk("t2_c4_rdata", bus0.o_req_rdata, 32'h1);
    req_rd = 2'b00;
    cyc();
    chk("t2_c5_ack",  {30'd0, bus0.o_req_ack}, 0);
    chk("t2_c5_hold", bus0.o_req_rdata, 32'h1);

    // 3: both requesters read continuously; grants alternate 0,1,... from pointer 0
    req_rd = 2'b11; req_addr = {3'd2, 3'd1};
    for (int t = 0; t < 8; t++) begin
      int n;
      n = 0;
      do begin
        cyc();
        n++;
      end while (bus0.o_req_ack == 2'b00 && n < 12);
      chk("t3_ack",   {30'd0, bus0.o_req_ack}, (t % 2 == 0) ? 32'd1 : 32'd2);
      chk("t3_rdata", bus0.o_req_rdata, (t % 2 == 0) ? 32'h3 : 32'h1);
    end
    req_rd = 2'b00;
    cyc();

    // 4: rd+wr together on req0 is a write
    req_rd = 2'b01; req_wr = 2'b01; req_addr[2:0] = 3'd3; req_wdata[31:0] = 32'hA5;
    cyc();
    chk("t4_c1_rd", bus0.o_dc_read, 0);
    cyc();
    chk("t4_c2_wr",    bus0.o_dc_write, 1);
    chk("t4_c2_rd",    bus0.o_dc_read, 0);
    chk("t4_c2_wdata", bus0.o_dc_writedata, 32'hA5);
    cyc();
    chk("t4_c3_ack", {30'd0, bus0.o_req_ack}, 1);
    chk("t4_c3_rd",  bus0.o_dc_read, 0);
    req_rd = 2'b00; req_wr = 2'b00;
    cyc();

    // 5a: offset 0 write with bit0=0 does not lock (pointer at 1 wraps to req0)
    req_wr = 2'b01; req_addr[2:0] = 3'd0; req_wdata[31:0] = 32'h2;
    cyc(); cyc(); cyc();
    chk("t5a_ack", {30'd0, bus0.o_req_ack}, 1);
    req_wr = 2'b00;
    cyc();
    chk("t5a_locked", bus0.o_locked, 0);

    // 5b: trigger write locks dut0 only
    req_wr = 2'b01; req_wdata[31:0] = 32'h1;
    cyc(); cyc(); cyc();
    chk("t5b_ack0", {30'd0, bus0.o_req_ack}, 1);
    chk("t5b_ack1", {30'd0, bus1.o_req_ack}, 1);
    req_wr = 2'b00;
    cyc();
    chk("t5b_locked0", bus0.o_locked, 1);
    chk("t5b_busy0",   bus0.o_busy, 0);
    chk("t5b_locked1", bus1.o_locked, 0);

    req_rd = 2'b10; req_addr[5:3] = 3'd2;
    act0 = 1'b0; got1 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cyc();
      act0 = act0 | (|bus0.o_req_ack) | bus0.o_dc_read | bus0.o_dc_write;
      if (bus1.o_req_ack == 2'b10) begin
        got1   = 1'b1;
        req_rd = 2'b00;
      end
    end
    req_rd = 2'b00;
    chk("t5_locked_activity", act0, 0);
    chk("t5_locked_still",    bus0.o_locked, 1);
    chk("t5_nolock_served",   got1, 1);
    chk("t5_nolock_rdata",    bus1.o_req_rdata, 32'h1);

    // 6: reset in WAIT; pointer returns to 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_unlock", bus0.o_locked, 0);
    req_rd = 2'b01; req_addr = {3'd2, 3'd1};
    cyc(); cyc(); cyc();
    chk("t6_wait_busy", bus0.o_busy, 1);
    chk("t6_wait_ack",  {30'd0, bus0.o_req_ack}, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy",  bus0.o_busy, 0);
    chk("t6_rst_addr",  {29'd0, bus0.o_dc_addr}, 0);
    chk("t6_rst_strb",  {30'd0, bus0.o_dc_read, bus0.o_dc_write}, 0);
    chk("t6_rst_rdata", bus1.o_req_rdata, 0);
    req_rd = 2'b11;
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_c1_busy", bus0.o_busy, 1);
    chk("t6_c1_addr", {29'd0, bus0.o_dc_addr}, 1);
    cyc();
    chk("t6_c2_rd", bus0.o_dc_read, 1);
    cyc(); cyc();
    chk("t6_c4_ack0",  {30'd0, bus0.o_req_ack}, 1);
    chk("t6_c4_ack1",  {30'd0, bus1.o_req_ack}, 1);
    chk("t6_c4_rdata", bus0.o_req_rdata, 32'h3);
    req_rd = 2'b00;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
